// File: rtl/mac_reg_arbiter.sv
// mac_reg_arbiter: round-robin N-way arbiter sharing one MAC register (MCI) master.
// Define MAC_REG_ARB_TIMEOUT_EN to build the i_mci_ack timeout.
module mac_reg_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_wr_data,
  input  logic [NUM_REQ-1:0]        i_rdwn,
  output logic [NUM_REQ-1:0]        o_done,
  output logic                      o_err,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_busy,
  output logic                      o_mci_val,
  output logic [ADDR_W-1:0]         o_mci_addr,
  output logic [DATA_W-1:0]         o_mci_wdata,
  output logic [DATA_W/8-1:0]       o_mci_be,
  output logic                      o_mci_rdwn,
  input  logic                      i_mci_ack,
  input  logic [DATA_W-1:0]         i_mci_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic               val_q, val_d;
  logic               rdwn_q, rdwn_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rd_q, rd_d;

  logic               found;
  logic [IDX_W-1:0]   win;
  logic [IDX_W:0]     cand;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_rdwn;
  logic               timeout;

`ifdef MAC_REG_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT && !i_mci_ack && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
  assign timeout = 1'b0;
`endif

  // Rotating search starting one past the last completed owner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(i + 1);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!found && i_req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end
    end
    sel_addr  = '0;
    sel_wdata = '0;
    sel_rdwn  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win == IDX_W'(k)) begin
        sel_addr  = i_addr[k*ADDR_W +: ADDR_W];
        sel_wdata = i_wr_data[k*DATA_W +: DATA_W];
        sel_rdwn  = i_rdwn[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    val_d   = val_q;
    rdwn_d  = rdwn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    done_d  = '0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d      = S_WAIT;
          idx_d        = win;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          busy_d       = 1'b1;
          val_d        = 1'b1;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          rdwn_d       = sel_rdwn;
        end
      end
      S_WAIT: begin
        if (i_mci_ack) begin
          state_d = S_DONE;
          rd_d    = rdwn_q ? i_mci_rdata : '0;
          val_d   = 1'b0;
          done_d  = grant_q;
          last_d  = idx_q;
        end else if (timeout) begin
          state_d = S_DONE;
          rd_d    = '0;
          val_d   = 1'b0;
          done_d  = grant_q;
          err_d   = 1'b1;
          last_d  = idx_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      idx_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      val_q   <= 1'b0;
      rdwn_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      val_q   <= val_d;
      rdwn_q  <= rdwn_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
    end
  end

  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_rd_data   = rd_q;
  assign o_grant     = grant_q;
  assign o_busy      = busy_q;
  assign o_mci_val   = val_q;
  assign o_mci_addr  = addr_q;
  assign o_mci_wdata = wdata_q;
  assign o_mci_be    = {(DATA_W/8){1'b1}};
  assign o_mci_rdwn  = rdwn_q;

endmodule

// File: tb/tb_mac_reg_arbiter.sv
// tb_mac_reg_arbiter: directed table, corner sequences and a randomized
// transaction-level reference model for mac_reg_arbiter.
module tb_mac_reg_arbiter;

  localparam int N  = 3;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  rdwn;
  logic [AW-1:0] addr_v [N];
  logic [DW-1:0] wd_v [N];
  logic [N*AW-1:0] addr_p;
  logic [N*DW-1:0] wd_p;
  logic          ack;
  logic [DW-1:0] rdata;

  logic [N-1:0]    o_done;
  logic            o_err;
  logic [DW-1:0]   o_rd_data;
  logic [N-1:0]    o_grant;
  logic            o_busy;
  logic            o_mci_val;
  logic [AW-1:0]   o_mci_addr;
  logic [DW-1:0]   o_mci_wdata;
  logic [DW/8-1:0] o_mci_be;
  logic            o_mci_rdwn;

  assign addr_p = {addr_v[2], addr_v[1], addr_v[0]};
  assign wd_p   = {wd_v[2], wd_v[1], wd_v[0]};

  mac_reg_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_addr(addr_p),
    .i_wr_data(wd_p), .i_rdwn(rdwn), .o_done(o_done), .o_err(o_err),
    .o_rd_data(o_rd_data), .o_grant(o_grant), .o_busy(o_busy),
    .o_mci_val(o_mci_val), .o_mci_addr(o_mci_addr),
    .o_mci_wdata(o_mci_wdata), .o_mci_be(o_mci_be),
    .o_mci_rdwn(o_mci_rdwn), .i_mci_ack(ack), .i_mci_rdata(rdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0]  req;
    logic          ack;
    logic [DW-1:0] rdata;
    logic          e_val;
    logic [N-1:0]  e_grant;
    logic [N-1:0]  e_done;
    logic          e_busy;
    logic [DW-1:0] e_rd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_rdwn;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(
    input logic [N-1:0] r, input logic a, input logic [DW-1:0] rd,
    input logic v, input logic [N-1:0] g, input logic [N-1:0] d,
    input logic b, input logic [DW-1:0] erd, input logic [AW-1:0] ea,
    input logic [DW-1:0] ew, input logic erw);
    vec_t x;
    x.req = r; x.ack = a; x.rdata = rd;
    x.e_val = v; x.e_grant = g; x.e_done = d; x.e_busy = b;
    x.e_rd = erd; x.e_addr = ea; x.e_wdata = ew; x.e_rdwn = erw;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_val(input string name, input int bound);
    int n;
    n = 0;
    while (!o_mci_val && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (!o_mci_val) begin
      failures++;
      $display("FAIL %s: o_mci_val never rose within %0d cycles", name, bound);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // reference model state
  int            m_state, m_last, m_own, m_wcnt, kk;
  logic          m_found;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic          m_rd;
  logic          e_val, e_busy;
  logic [N-1:0]  e_grant, e_done;
  logic [DW-1:0] e_rd;
  int            gcnt [N];
  int            hi;

  initial begin
    rst = 1'b1; req = '0; ack = 1'b0; rdata = '0; rdwn = '0;
    for (int k = 0; k < N; k++) begin
      addr_v[k] = '0;
      wd_v[k]   = '0;
    end
    do_reset();

    chk("rst_val", 32'(o_mci_val), 32'h0);
    chk("rst_grant", 32'(o_grant), 32'h0);
    chk("rst_done", 32'(o_done), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_err", 32'(o_err), 32'h0);
    chk("rst_rd", o_rd_data, 32'h0);
    chk("rst_addr", 32'(o_mci_addr), 32'h0);
    chk("rst_wdata", o_mci_wdata, 32'h0);
    chk("rst_rdwn", 32'(o_mci_rdwn), 32'h0);
    chk("be", 32'(o_mci_be), 32'hF);

    addr_v[0] = 14'h0123; wd_v[0] = 32'h0;          rdwn[0] = 1'b1;
    addr_v[1] = 14'h0040; wd_v[1] = 32'h0;          rdwn[1] = 1'b1;
    addr_v[2] = 14'h0010; wd_v[2] = 32'hA5A5_0001; rdwn[2] = 1'b0;

    tbl[0] = mk(3'b010, 0, 0,            0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
    tbl[1] = mk(3'b010, 0, 0,            1, 3'b010, 3'b000, 1, 0, 14'h40, 0, 1);
    tbl[2] = mk(3'b010, 0, 0,            1, 3'b010, 3'b000, 1, 0, 14'h40, 0, 1);
    tbl[3] = mk(3'b010, 1, 32'h796D,     1, 3'b010, 3'b000, 1, 0, 14'h40, 0, 1);
    tbl[4] = mk(3'b000, 0, 0,            0, 3'b010, 3'b010, 1, 32'h796D, 0, 0, 0);
    tbl[5] = mk(3'b000, 1, 32'hFFFF_FFFF, 0, 3'b000, 3'b000, 0, 32'h796D, 0, 0, 0);
    tbl[6] = mk(3'b100, 0, 0,            0, 3'b000, 3'b000, 0, 32'h796D, 0, 0, 0);
    tbl[7] = mk(3'b100, 1, 32'hDEAD_BEEF, 1, 3'b100, 3'b000, 1, 32'h796D,
                14'h10, 32'hA5A5_0001, 0);
    tbl[8] = mk(3'b000, 0, 0,            0, 3'b100, 3'b100, 1, 0, 0, 0, 0);
    tbl[9] = mk(3'b000, 0, 0,            0, 3'b000, 3'b000, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t%0d_val", i), 32'(o_mci_val), 32'(tbl[i].e_val));
      chk($sformatf("t%0d_grant", i), 32'(o_grant), 32'(tbl[i].e_grant));
      chk($sformatf("t%0d_done", i), 32'(o_done), 32'(tbl[i].e_done));
      chk($sformatf("t%0d_busy", i), 32'(o_busy), 32'(tbl[i].e_busy));
      chk($sformatf("t%0d_rd", i), o_rd_data, tbl[i].e_rd);
      chk($sformatf("t%0d_err", i), 32'(o_err), 32'h0);
      if (tbl[i].e_val) begin
        chk($sformatf("t%0d_addr", i), 32'(o_mci_addr), 32'(tbl[i].e_addr));
        chk($sformatf("t%0d_wdata", i), o_mci_wdata, tbl[i].e_wdata);
        chk($sformatf("t%0d_rdwn", i), 32'(o_mci_rdwn), 32'(tbl[i].e_rdwn));
      end
      req   = tbl[i].req;
      ack   = tbl[i].ack;
      rdata = tbl[i].rdata;
      tick();
    end

    // request raised during the DONE cycle is served next
    req = 3'b001;
    tick();
    chk("late_val0", 32'(o_mci_val), 32'h1);
    chk("late_grant0", 32'(o_grant), 32'h1);
    ack = 1'b1; rdata = 32'h1111;
    tick();
    chk("late_done0", 32'(o_done), 32'h1);
    ack = 1'b0;
    req = 3'b010;
    tick();
    chk("late_idle", 32'(o_mci_val), 32'h0);
    chk("late_idle_busy", 32'(o_busy), 32'h0);
    tick();
    chk("late_val1", 32'(o_mci_val), 32'h1);
    chk("late_grant1", 32'(o_grant), 32'h2);
    ack = 1'b1;
    tick();
    chk("late_done1", 32'(o_done), 32'h2);
    ack = 1'b0; req = '0;
    tick();

    // fairness with all requesters held
    do_reset();
    for (int k = 0; k < N; k++) gcnt[k] = 0;
    req = 3'b111;
    for (int t = 0; t < 6; t++) begin
      wait_val($sformatf("rr%0d_wait", t), 10);
      chk($sformatf("rr%0d_grant", t), 32'(o_grant), 32'(1 << (t % N)));
      for (int k = 0; k < N; k++) if (o_grant[k]) gcnt[k]++;
      tick();
      ack = 1'b1; rdata = 32'h5555_0000 + 32'(t);
      tick();
      ack = 1'b0;
      chk($sformatf("rr%0d_done", t), 32'(o_done), 32'(1 << (t % N)));
    end
    req = '0;
    for (int k = 0; k < N; k++) chk($sformatf("rr_cnt%0d", k), 32'(gcnt[k]), 32'd2);
    tick();

    // reset while waiting for ack
    req = 3'b100;
    wait_val("mr_wait", 10);
    tick();
    rst = 1'b1;
    tick();
    chk("mr_val", 32'(o_mci_val), 32'h0);
    chk("mr_grant", 32'(o_grant), 32'h0);
    chk("mr_busy", 32'(o_busy), 32'h0);
    chk("mr_done", 32'(o_done), 32'h0);
    chk("mr_err", 32'(o_err), 32'h0);
    chk("mr_rd", o_rd_data, 32'h0);
    chk("mr_addr", 32'(o_mci_addr), 32'h0);
    chk("mr_wdata", o_mci_wdata, 32'h0);
    rst = 1'b0;
    req = 3'b101;
    tick();
    chk("mr_nodone", 32'(o_done), 32'h0);
    chk("mr_first", 32'(o_grant), 32'h1);
    ack = 1'b1;
    tick();
    ack = 1'b0; req = '0;
    tick();
    tick();

    // hung MAC
    req = 3'b010;
    wait_val("to_wait", 10);
    hi = 0;
`ifdef MAC_REG_ARB_TIMEOUT_EN
    while (o_mci_val && hi < 100) begin
      hi++;
      tick();
    end
    chk("to_val_cycles", 32'(hi), 32'(TO));
    chk("to_done", 32'(o_done), 32'h2);
    chk("to_err", 32'(o_err), 32'h1);
    chk("to_rd", o_rd_data, 32'h0);
    req = '0;
    tick();
`else
    for (int c = 0; c < 1100; c++) begin
      if (o_mci_val && o_done == '0) hi++;
      tick();
    end
    chk("noto_val_cycles", 32'(hi), 32'd1100);
    ack = 1'b1;
    tick();
    ack = 1'b0; req = '0;
    chk("noto_done", 32'(o_done), 32'h2);
    chk("noto_err", 32'(o_err), 32'h0);
`endif
    tick();

    // randomized traffic against the reference model
    do_reset();
    m_state = 0; m_last = N - 1; m_own = 0; m_wcnt = 0;
    m_addr = '0; m_wd = '0; m_rd = 1'b0;
    e_val = 0; e_busy = 0; e_grant = '0; e_done = '0; e_rd = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      chk("rnd_val", 32'(o_mci_val), 32'(e_val));
      chk("rnd_grant", 32'(o_grant), 32'(e_grant));
      chk("rnd_done", 32'(o_done), 32'(e_done));
      chk("rnd_busy", 32'(o_busy), 32'(e_busy));
      chk("rnd_rd", o_rd_data, e_rd);
      chk("rnd_err", 32'(o_err), 32'h0);
      if (e_val) begin
        chk("rnd_addr", 32'(o_mci_addr), 32'(m_addr));
        chk("rnd_wdata", o_mci_wdata, m_wd);
        chk("rnd_rdwn", 32'(o_mci_rdwn), 32'(m_rd));
      end
      for (int k = 0; k < N; k++) begin
        if (e_done[k]) begin
          req[k] = 1'b0;
        end else if (!req[k] && $urandom_range(3) == 0) begin
          req[k]    = 1'b1;
          addr_v[k] = AW'($urandom);
          wd_v[k]   = $urandom;
          rdwn[k]   = 1'($urandom);
        end
      end
      if (m_state == 1 && $urandom_range(1) == 1) begin
        addr_v[m_own] = AW'($urandom);
        wd_v[m_own]   = $urandom;
      end
      ack   = ($urandom_range(2) == 0) || (m_state == 1 && m_wcnt >= 8);
      rdata = $urandom;
      case (m_state)
        0: begin
          e_val = 0; e_busy = 0; e_grant = '0; e_done = '0;
          m_found = 1'b0;
          for (int i = 1; i <= N; i++) begin
            kk = (m_last + i) % N;
            if (!m_found && req[kk]) begin
              m_found = 1'b1;
              m_own   = kk;
            end
          end
          if (m_found) begin
            m_addr  = addr_v[m_own];
            m_wd    = wd_v[m_own];
            m_rd    = rdwn[m_own];
            e_val   = 1;
            e_busy  = 1;
            e_grant = N'(1) << m_own;
            m_wcnt  = 0;
            m_state = 1;
          end
        end
        1: begin
          if (ack) begin
            e_done  = N'(1) << m_own;
            e_rd    = m_rd ? rdata : '0;
            e_val   = 0;
            m_last  = m_own;
            m_state = 2;
          end else begin
            m_wcnt++;
          end
        end
        default: begin
          e_val = 0; e_busy = 0; e_grant = '0; e_done = '0;
          m_state = 0;
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_reg_arbiter.md
# mac_reg_arbiter

Parametrised N-way arbiter for the MAC register (MCI) port. It replaces the fixed two-source poll/PHY mux in the MAC speed-control path. Any number of requesters (speed poller, PHY MDIO access, host CSR bridge, statistics reader, ...) can share one `MAC_REG_ACCESS`-style MCI master. Arbitration is round-robin, each transaction is tracked with its own done/error return, and an optional ack timeout protects against a hung MAC.

## Interface
Parameters:
- `NUM_REQ`, default 3: number of requesters, 2..8.
- `ADDR_W`, default 14: MCI address width.
- `DATA_W`, default 32: MCI data width; must be a multiple of 8.
- `TIMEOUT_CYC`, default 1024: cycles waited for `i_mci_ack` before abort. Used only with `MAC_REG_ARB_TIMEOUT_EN`.

Ports:
- `i_clk` in 1: the single clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_req` in NUM_REQ: per-requester request, level-held until its `o_done`.
- `i_addr` in NUM_REQ*ADDR_W: packed addresses; requester k occupies slice k.
- `i_wr_data` in NUM_REQ*DATA_W: packed write data.
- `i_rdwn` in NUM_REQ: 1 = read, 0 = write.
- `o_done` out NUM_REQ: one-cycle completion pulse for requester k.
- `o_err` out 1: valid with any `o_done`; 1 = timed out.
- `o_rd_data` out DATA_W: read data, valid with `o_done`; held until the next `o_done`.
- `o_grant` out NUM_REQ: one-hot current owner; 0 when idle.
- `o_busy` out 1: transaction in flight.
- `o_mci_val` out 1: MCI request valid.
- `o_mci_addr` out ADDR_W: MCI address.
- `o_mci_wdata` out DATA_W: MCI write data.
- `o_mci_be` out DATA_W/8: byte enables; always all ones.
- `o_mci_rdwn` out 1: MCI read/not-write.
- `i_mci_ack` in 1: MCI completion.
- `i_mci_rdata` in DATA_W: MCI read data, valid with `i_mci_ack`.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE**
  - If any `i_req` bit is set, pick the winner by round-robin.
  - The search starts at `last+1` mod NUM_REQ.
  - Register the winner's addr, wdata and rdwn into the MCI outputs; set `o_grant`, `o_mci_val` and `o_busy`.
  - Go to WAIT.
- **WAIT**
  - `o_mci_val` and all MCI outputs are held stable.
  - On `i_mci_ack`:
    - capture `i_mci_rdata` into `o_rd_data` (writes capture 0);
    - clear `o_mci_val`;
    - pulse `o_done[grant]` with `o_err`=0;
    - set `last` to the grant;
    - go to DONE.
- **DONE**
  - Lasts one cycle, with `o_done` high.
  - Requests are ignored in this cycle.
  - `o_grant` and `o_busy` clear on exit.
  - Next state is IDLE.
- Requester contract: drop `i_req` on the edge ending its `o_done` cycle. A request still high in the following IDLE is treated as a new transaction.
- Changes to a requester's `i_addr` or `i_wr_data` after grant have no effect; the values are latched.
- `i_mci_ack` outside WAIT is ignored.
- Requests arriving during WAIT or DONE wait for the next IDLE; none are lost.
- Round-robin: a requester that holds `i_req` continuously is granted within NUM_REQ transactions.
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - `last` = NUM_REQ-1, so requester 0 has first priority;
  - timeout counter 0.
- Reset mid-transaction:
  - `o_mci_val` drops on the reset edge;
  - no `o_done` is issued;
  - requesters must re-request.

## Timing
- `i_req` high in IDLE at cycle 0 → `o_mci_val` high in cycle 1.
- Earliest `i_mci_ack` is in cycle 1 → `o_done` in cycle 2 → IDLE in cycle 3.
- Minimum turnaround is 3 cycles per transaction.
- `o_mci_val` stays high from cycle 1 through the ack cycle inclusive and is low the cycle after.
- `o_rd_data` and `o_err` are registered and coincident with `o_done`.

## Configuration
- `MAC_REG_ARB_TIMEOUT_EN` defined:
  - a counter of width `$clog2(TIMEOUT_CYC)`, clear on entry to WAIT, increments each WAIT cycle without ack;
  - when it reaches TIMEOUT_CYC-1 with no ack: `o_mci_val` drops, FSM goes to DONE, `o_done[grant]`=1, `o_err`=1, `o_rd_data`=0;
  - ack and the timeout in the same cycle: the ack wins, `o_err`=0.
- `MAC_REG_ARB_TIMEOUT_EN` undefined:
  - no counter is built;
  - WAIT holds indefinitely;
  - `o_err` is tied to 0.

## Test plan
- **Single read:** NUM_REQ=3; `i_req`=3'b010, addr 14'h0040, `i_mci_ack` in cycle 3 with rdata 32'h0000_796D → `o_mci_val` high in cycles 1–3, `o_mci_addr`=14'h0040, `o_mci_rdwn`=1, `o_done`=3'b010 in cycle 4, `o_rd_data`=32'h0000_796D, `o_err`=0.
- **Round-robin fairness:** all three requesters held high, ack always 1 cycle after val → grant order is 0, 1, 2, 0, 1, 2, and no requester is granted twice before the others.
- **Write beat:** requester 2 writes 32'hA5A5_0001 to 14'h0010 → `o_mci_wdata`=32'hA5A5_0001, `o_mci_be`=4'hF, `o_mci_rdwn`=0, `o_rd_data`=0 at `o_done`.
- **Late and stray events:** a request arrives in the DONE cycle and is served in the next transaction; an `i_mci_ack` pulse in IDLE produces no `o_done`.
- **Reset mid-operation:** assert `i_rst` during WAIT → all outputs 0 on the next cycle, no `o_done`, and requester 0 is granted first afterwards.
- **Timeout (macro on):** TIMEOUT_CYC=16, no ack → `o_mci_val` high for 16 cycles, then `o_done` with `o_err`=1, `o_rd_data`=0. With the macro off, the same stimulus keeps `o_mci_val` high for more than 1000 cycles.
